arbiter_rr: RTL and testbench

Parametrised N-requester synchronous arbiter: the next generation of the team's four-channel fixed-priority arbiter. It selects between fixed-priority and round-robin policy at run time and holds a grant until the owner releases its request. An optional maximum-hold timeout forcibly reclaims a grant from a stuck owner. It sits between N bus masters and a single shared resource; grants are registered and one-hot.

---
 rtl/arbiter_pkg.sv | 16 +
 rtl/arb_rr_pick.sv | 42 ++++
 rtl/arbiter_rr.sv | 142 ++++++++++++++
 tb/tb_arbiter_rr.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
// Shared types, mode constants and index-width helper for the arbiter_rr block.
package arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int calc_idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational winner selection: highest index in fixed mode, first set bit
// after ptr (wrapping) in round-robin mode. Masked requesters are never picked.
module arb_rr_pick
  import arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = calc_idw(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDW-1:0]   ptr_i,
  input  logic             mode_i,
  input  logic [N_REQ-1:0] mask_i,
  output logic [IDW-1:0]   winner_o,
  output logic             valid_o
);

  logic [N_REQ-1:0] cand;

  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return IDW'(s);
  endfunction

  always_comb begin
    cand     = req_i & ~mask_i;
    valid_o  = |cand;
    winner_o = '0;
    if (mode_i == MODE_RR) begin
      // Scan farthest-first so the nearest set bit after ptr is the final assignment.
      for (int k = N_REQ; k >= 1; k--) begin
        if (cand[wrap_idx(ptr_i, k)]) winner_o = wrap_idx(ptr_i, k);
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (cand[IDW'(i)]) winner_o = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/arbiter_rr.sv
// N-requester arbiter with run-time fixed/round-robin policy and hold-until-release grants.
// Optional forced release after HOLD_MAX cycles when ARBITER_TIMEOUT_EN is defined.
module arbiter_rr
  import arbiter_pkg::*;
#(
  parameter int  N_REQ    = 4,
  parameter int  HOLD_MAX = 16,
  localparam int IDW      = calc_idw(N_REQ)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             mode_i,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             gnt_valid_o,
  output logic [IDW-1:0]   gnt_id_o,
  output logic             timeout_o
);

  if (N_REQ < 2 || N_REQ > 32 || HOLD_MAX < 2 || HOLD_MAX > 65535) begin : g_param_check
    $error("arbiter_rr: N_REQ or HOLD_MAX out of range");
  end

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0] pick_mask;
  logic [IDW-1:0]   pick_winner;
  logic             pick_valid;
  logic             owner_req;

  assign owner_req = req_i[gnt_id_q];

`ifdef ARBITER_TIMEOUT_EN
  localparam int HOLD_W = $clog2(HOLD_MAX + 1);
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_q, timeout_d;
  logic [N_REQ-1:0]  owner_oh;

  always_comb begin
    owner_oh           = '0;
    owner_oh[gnt_id_q] = 1'b1;
    // After a forced release, skip the stuck owner only if someone else is waiting.
    pick_mask = (timeout_q && |(req_i & ~owner_oh)) ? owner_oh : '0;
  end
  assign timeout_o = timeout_q;
`else
  assign pick_mask = '0;
  assign timeout_o = 1'b0;
`endif

  arb_rr_pick #(
    .N_REQ(N_REQ),
    .IDW  (IDW)
  ) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .mode_i  (mode_i),
    .mask_i  (pick_mask),
    .winner_o(pick_winner),
    .valid_o (pick_valid)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_id_d    = gnt_id_q;
    ptr_d       = ptr_q;
`ifdef ARBITER_TIMEOUT_EN
    hold_d      = hold_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef ARBITER_TIMEOUT_EN
        hold_d = '0;
`endif
        if (pick_valid) begin
          state_d             = GRANT;
          gnt_d               = '0;
          gnt_d[pick_winner]  = 1'b1;
          gnt_valid_d         = 1'b1;
          gnt_id_d            = pick_winner;
          ptr_d               = pick_winner;
`ifdef ARBITER_TIMEOUT_EN
          hold_d              = HOLD_W'(1);
`endif
        end
      end
      GRANT: begin
        if (!owner_req) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
        end
`ifdef ARBITER_TIMEOUT_EN
        else if (hold_q == HOLD_W'(HOLD_MAX)) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          timeout_d   = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      ptr_q       <= IDW'(N_REQ - 1);
`ifdef ARBITER_TIMEOUT_EN
      hold_q      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      ptr_q       <= ptr_d;
`ifdef ARBITER_TIMEOUT_EN
      hold_q      <= hold_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_valid_o = gnt_valid_q;
  assign gnt_id_o    = gnt_id_q;

endmodule

// File: tb/tb_arbiter_rr.sv
// Randomised and directed bench for arbiter_rr against a cycle-level behavioural model.
module tb_arbiter_rr;

  localparam int N    = 4;
  localparam int HOLD = 4;
`ifdef ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         mode  = 1'b0;
  logic [N-1:0] req   = '0;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [1:0]   gnt_id;
  logic         timeout;

  always #5 clk = ~clk;

  arbiter_rr #(
    .N_REQ   (N),
    .HOLD_MAX(HOLD)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .mode_i     (mode),
    .req_i      (req),
    .gnt_o      (gnt),
    .gnt_valid_o(gnt_valid),
    .gnt_id_o   (gnt_id),
    .timeout_o  (timeout)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state: who owns the resource, last owner, rr pointer, hold length, timeout pulse.
  bit m_busy;
  int m_id;
  int m_ptr;
  int m_hold;
  bit m_to;

  always @(negedge clk) begin
    assert ($onehot0(gnt)) else $error("FAIL onehot: gnt=%b not one-hot or zero", gnt);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_id   = 0;
    m_ptr  = N - 1;
    m_hold = 0;
    m_to   = 1'b0;
  endtask

  function automatic int ref_pick(input logic [N-1:0] r, input bit rr, input int ptr);
    if (!rr) begin
      for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic [N-1:0] r, input bit m);
    logic [N-1:0] cand;
    logic [N-1:0] own;
    int           w;
    bit           to_next;
    to_next = 1'b0;
    own     = '0;
    own[m_id] = 1'b1;
    if (!m_busy) begin
      cand = r;
      if (m_to && ((r & ~own) != '0)) cand = r & ~own;
      w = ref_pick(cand, m, m_ptr);
      if (w >= 0) begin
        m_busy = 1'b1;
        m_id   = w;
        m_ptr  = w;
        m_hold = 1;
      end
    end else if (!r[m_id]) begin
      m_busy = 1'b0;
    end else if (TO_EN && m_hold == HOLD) begin
      m_busy  = 1'b0;
      to_next = 1'b1;
    end else begin
      m_hold++;
    end
    m_to = to_next;
  endtask

  task automatic check_outputs(input string ctx);
    logic [N-1:0] eg;
    eg = '0;
    if (m_busy) eg[m_id] = 1'b1;
    check({ctx, ".gnt"},       32'(gnt),       32'(eg));
    check({ctx, ".gnt_valid"}, 32'(gnt_valid), 32'(m_busy));
    check({ctx, ".gnt_id"},    32'(gnt_id),    32'(m_id));
    check({ctx, ".timeout"},   32'(timeout),   32'(m_to));
    $display("[%0t] %s req=%b mode=%0d gnt=%b valid=%0d id=%0d to=%0d",
             $time, ctx, req, mode, gnt, gnt_valid, gnt_id, timeout);
  endtask

  task automatic tick(input string ctx);
    @(posedge clk);
    model_edge(req, mode);
    #1;
    check_outputs(ctx);
  endtask

  task automatic step(input logic [N-1:0] r, input bit m, input string ctx);
    @(negedge clk);
    req  = r;
    mode = m;
    tick(ctx);
  endtask

  initial begin
    logic [N-1:0] r;
    bit           m;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    repeat (3) step(4'b0000, 1'b0, "idle");

    repeat (3) step(4'b0110, 1'b0, "fixed");
    repeat (3) step(4'b0010, 1'b0, "fixed_drop2");
    repeat (2) step(4'b0000, 1'b0, "fixed_rel");

    repeat (2) step(4'b0010, 1'b0, "mode_own1");
    repeat (2) step(4'b1011, 1'b1, "mode_sw");
    repeat (3) step(4'b1001, 1'b1, "mode_rel");
    repeat (2) step(4'b0000, 1'b1, "mode_idle");

    // Round-robin with every owner dropping after three grant cycles.
    for (int c = 0; c < 24; c++) begin
      r = 4'b1111;
      if (m_busy && m_hold == 3) r[m_id] = 1'b0;
      step(r, 1'b1, "rr_fair");
    end
    repeat (2) step(4'b0000, 1'b0, "rr_idle");

    repeat (8) step(4'b0011, 1'b0, "hold_2req");
    repeat (2) step(4'b0000, 1'b0, "hold_gap");
    repeat (8) step(4'b0010, 1'b0, "hold_1req");
    repeat (2) step(4'b0000, 1'b0, "hold_idle");

    repeat (3) step(4'b1000, 1'b0, "pre_rst");
    @(posedge clk);
    model_edge(req, mode);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0001;
    tick("post_rst");
    repeat (2) step(4'b0000, 1'b0, "post_idle");

    r = '0;
    m = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      if ($urandom_range(0, 15) == 0) r = '0;
      if ($urandom_range(0, 9) == 0) m = ~m;
      step(r, m, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
